cnt_job_driver: RTL

//  Initiator/datapath side of the counter-FSM job protocol. Queues count requests in a small

---
 rtl/cnt_job_pkg.sv | 18 +
 rtl/cnt_job_fifo.sv | 45 ++++
 rtl/cnt_job_driver.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cnt_job_pkg.sv
// Shared types and constants for the counter-FSM job driver.
// The state enum and the error bit positions are used by the driver and by anything decoding err_o.
package cnt_job_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        RUN       = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int ERR_WIDTH      = 3;
    localparam int ERR_NO_RUN     = 0;
    localparam int ERR_STRAY_DONE = 1;
    localparam int ERR_OVERFLOW   = 2;
    localparam int JOBS_WIDTH     = 16;

endpackage

// File: rtl/cnt_job_fifo.sv
// Synchronous request FIFO; occupancy is tracked with read/write pointers carrying one extra wrap bit.
// A push is still taken when full if a pop happens in the same cycle.
module cnt_job_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cnt_job_driver.sv
// Initiator side of the counter-FSM job protocol: queues requests, issues start/terminal count,
// drives the running count while the FSM is in RUN, retires jobs on done and records protocol errors.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | no job active; pops the FIFO head when a request is queued
//  START     | one-cycle start pulse, running count cleared
//  RUN       | FSM reports run; count advances on each run cycle
//  WAIT_DONE | run dropped before done; count held until done arrives
module cnt_job_driver
    import cnt_job_pkg::*;
#(
    parameter int CNT_WIDTH  = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [CNT_WIDTH-1:0]  req_cnt_val_i,
    output logic                  start_o,
    output logic [CNT_WIDTH-1:0]  cnt_val_o,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    input  logic                  run_i,
    input  logic                  done_i,
    output logic                  busy_o,
    output logic                  job_done_o,
    output logic [JOBS_WIDTH-1:0] jobs_cnt_o,
    output logic [ERR_WIDTH-1:0]  err_o
);
    state_t               state;
    state_t               state_nxt;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_WIDTH-1:0] fifo_head;
    logic                 first_run;
    logic                 retire;
    logic                 no_run;
    logic                 stray_done;
    logic                 cnt_inc;

    assign req_ready_o = !fifo_full;
    assign fifo_push   = req_valid_i && req_ready_o;
    assign start_o     = (state == START);
    assign busy_o      = (state != IDLE) || !fifo_empty;
    assign cnt_inc     = (state == RUN) && run_i;

    cnt_job_fifo #(
        .WIDTH (CNT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (req_cnt_val_i),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt  = state;
        fifo_pop   = 1'b0;
        retire     = 1'b0;
        no_run     = 1'b0;
        stray_done = 1'b0;
        case (state)
            IDLE: begin
                stray_done = done_i;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                stray_done = done_i;
                state_nxt  = RUN;
            end
            RUN: begin
                // done wins over a dropped run: the FSM has already finished the job.
                if (done_i) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end else if (!run_i) begin
                    if (first_run) begin
                        no_run    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (done_i) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt_val_o  <= '0;
            cnt_o      <= '0;
            first_run  <= 1'b0;
            job_done_o <= 1'b0;
            jobs_cnt_o <= '0;
            err_o      <= '0;
        end else begin
            state      <= state_nxt;
            first_run  <= (state == START);
            job_done_o <= retire;
            if (retire)   jobs_cnt_o <= jobs_cnt_o + JOBS_WIDTH'(1);
            if (fifo_pop) cnt_val_o  <= fifo_head;
            if (state == START) begin
                cnt_o <= '0;
            end else if (cnt_inc) begin
                cnt_o <= cnt_o + CNT_WIDTH'(1);
            end
            if (no_run)                    err_o[ERR_NO_RUN]     <= 1'b1;
            if (stray_done)                err_o[ERR_STRAY_DONE] <= 1'b1;
            if (cnt_inc && (cnt_o == '1))  err_o[ERR_OVERFLOW]   <= 1'b1;
        end
    end

endmodule
